schedule_sequencer: RTL and testbench

- Parametrised step sequencer for the inverse-kinematics solver blocks (e.g. cholesky_block).
- Generalises the free-running modulo-MAX step counter shared by a block and its shared array multiplier and array divider.
- Adds start/done handshake, one-shot and free-run modes, abort, and en-gated delay taps that align step indices with results returning from the two shared pipelined units.

---
 rtl/schedule_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_schedule_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/schedule_sequencer.sv
// Purpose : step sequencer (modulo-MAX count) with start/done, one-shot/free-run, abort, LAT_A/LAT_B result-alignment taps.
// Latency : first step issued on the en-cycle after start; count_a/count_b trail count by LAT_A/LAT_B en-cycles.
// Backpres: en low freezes count, taps and state; start/abort act regardless of en; start while busy is dropped.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   en                global advance enable shared with the array multiplier/divider
//   start, mode       begin request (IDLE only); mode sampled with start: 0 one-shot, 1 free-run
//   abort             return to IDLE on next edge, clearing taps (priority over start)
//   count             current step index, valid while busy
//   busy, first, last RUN/DRAIN flag; RUN and count==0; RUN and count==MAX-1
//   count_a, valid_a  step index aligned with unit A results (LAT_A en-cycles)
//   count_b, valid_b  step index aligned with unit B results (LAT_B en-cycles)
//   done              one-cycle pulse when a one-shot pass has fully drained
//   pass_cnt          (SCHED_PASS_CNT_EN only) saturating count of completed passes
//
// Optional feature macro: SCHED_PASS_CNT_EN
// Parameter constraints: 2**CNT_W >= MAX, MAX >= 2, LAT_A >= 1, LAT_B >= LAT_A.

module schedule_sequencer #(
    parameter int CNT_W = 8,
    parameter int MAX   = 211,
    parameter int LAT_A = 3,
    parameter int LAT_B = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             first,
    output logic             last,
    output logic [CNT_W-1:0] count_a,
    output logic             valid_a,
    output logic [CNT_W-1:0] count_b,
    output logic             valid_b,
    output logic             done
`ifdef SCHED_PASS_CNT_EN
    ,
    output logic [15:0]      pass_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             mode_q, mode_nxt;
    logic             done_nxt;

    // Tap control from the next-state logic
    logic             shift;
    logic             clear_taps;
    logic             push_vld;
    logic [CNT_W-1:0] push_cnt;

    logic [CNT_W-1:0] tap_a_cnt [LAT_A];
    logic             tap_a_vld [LAT_A];
    logic [CNT_W-1:0] tap_b_cnt [LAT_B];
    logic             tap_b_vld [LAT_B];

    // A valid entry still in line B after the next shift means results are
    // still outstanding; that is every stage except the tail, which drops out.
    logic             b_pending;

    always_comb begin
        b_pending = 1'b0;
        for (int i = 0; i < LAT_B - 1; i++) begin
            b_pending = b_pending | tap_b_vld[i];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            mode_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            mode_q <= mode_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic; done_nxt defaults low so the pulse always clears on
    // the following edge even when en is low.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        mode_nxt   = mode_q;
        done_nxt   = 1'b0;
        shift      = 1'b0;
        clear_taps = 1'b0;
        push_vld   = 1'b0;
        push_cnt   = '0;

        if (abort) begin
            state_nxt  = IDLE;
            count_nxt  = '0;
            clear_taps = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    shift = en;
                    if (start) begin
                        state_nxt = RUN;
                        count_nxt = '0;
                        mode_nxt  = mode;
                    end
                end
                RUN: begin
                    if (en) begin
                        shift    = 1'b1;
                        push_vld = 1'b1;
                        push_cnt = count;
                        if (count == CNT_LAST) begin
                            count_nxt = '0;
                            if (!mode_q) begin
                                state_nxt = DRAIN;
                            end
                        end else begin
                            count_nxt = count + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (en) begin
                        shift = 1'b1;
                        if (!b_pending) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // Delay lines: stage 0 takes the pushed entry, stage LAT-1 is the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT_A; i++) begin
                tap_a_cnt[i] <= '0;
                tap_a_vld[i] <= 1'b0;
            end
            for (int i = 0; i < LAT_B; i++) begin
                tap_b_cnt[i] <= '0;
                tap_b_vld[i] <= 1'b0;
            end
        end else if (clear_taps) begin
            for (int i = 0; i < LAT_A; i++) begin
                tap_a_cnt[i] <= '0;
                tap_a_vld[i] <= 1'b0;
            end
            for (int i = 0; i < LAT_B; i++) begin
                tap_b_cnt[i] <= '0;
                tap_b_vld[i] <= 1'b0;
            end
        end else if (shift) begin
            tap_a_cnt[0] <= push_cnt;
            tap_a_vld[0] <= push_vld;
            for (int i = 1; i < LAT_A; i++) begin
                tap_a_cnt[i] <= tap_a_cnt[i-1];
                tap_a_vld[i] <= tap_a_vld[i-1];
            end
            tap_b_cnt[0] <= push_cnt;
            tap_b_vld[0] <= push_vld;
            for (int i = 1; i < LAT_B; i++) begin
                tap_b_cnt[i] <= tap_b_cnt[i-1];
                tap_b_vld[i] <= tap_b_vld[i-1];
            end
        end
    end

    assign count_a = tap_a_cnt[LAT_A-1];
    assign valid_a = tap_a_vld[LAT_A-1];
    assign count_b = tap_b_cnt[LAT_B-1];
    assign valid_b = tap_b_vld[LAT_B-1];

    assign busy  = (state != IDLE);
    assign first = (state == RUN) && (count == '0);
    assign last  = (state == RUN) && (count == CNT_LAST);

`ifdef SCHED_PASS_CNT_EN
    // Completed-pass counter; survives abort so software can see how far a
    // free-running job got before it was stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
        end else if (state == IDLE && start && !abort) begin
            pass_cnt <= '0;
        end else if (state == RUN && en && count == CNT_LAST && pass_cnt != 16'hFFFF) begin
            pass_cnt <= pass_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_schedule_sequencer.sv
module tb_schedule_sequencer;

    localparam int CNT_W = 8;
    localparam int MAX   = 211;
    localparam int LAT_A = 3;
    localparam int LAT_B = 12;

    logic             clk = 1'b0;
    logic             rst, en, start, mode, abort;
    logic [CNT_W-1:0] count, count_a, count_b;
    logic             busy, first, last, valid_a, valid_b, done;
`ifdef SCHED_PASS_CNT_EN
    logic [15:0]      pass_cnt;
`endif

    int errors = 0;
    int checks = 0;

    schedule_sequencer #(
        .CNT_W(CNT_W), .MAX(MAX), .LAT_A(LAT_A), .LAT_B(LAT_B)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .abort(abort),
        .count(count), .busy(busy), .first(first), .last(last),
        .count_a(count_a), .valid_a(valid_a), .count_b(count_b), .valid_b(valid_b),
        .done(done)
`ifdef SCHED_PASS_CNT_EN
        , .pass_cnt(pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start, mode, abort, en;
        int   e_count;
        logic e_busy, e_first, e_last, e_vld_a;
        int   e_cnt_a;
        logic e_vld_b, e_done;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0d, expected %0d", name, tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_count"},   0, int'(count), 0);
        chk({name, "_busy"},    0, busy, 0);
        chk({name, "_first"},   0, first, 0);
        chk({name, "_last"},    0, last, 0);
        chk({name, "_valid_a"}, 0, valid_a, 0);
        chk({name, "_count_a"}, 0, int'(count_a), 0);
        chk({name, "_valid_b"}, 0, valid_b, 0);
        chk({name, "_count_b"}, 0, int'(count_b), 0);
        chk({name, "_done"},    0, done, 0);
    endtask

    // Expected one-shot outputs after n en-edges past the start edge.
    task automatic check_pass(input int n, input bit done_exp, input int tag);
        bit va, vb;
        va = (n >= LAT_A) && (n < MAX + LAT_A);
        vb = (n >= LAT_B) && (n < MAX + LAT_B);
        chk("os_count",   tag, int'(count), (n <= MAX - 1) ? n : 0);
        chk("os_busy",    tag, busy, (n < MAX + LAT_B) ? 1 : 0);
        chk("os_first",   tag, first, (n == 0) ? 1 : 0);
        chk("os_last",    tag, last, (n == MAX - 1) ? 1 : 0);
        chk("os_done",    tag, done, done_exp ? 1 : 0);
        chk("os_valid_a", tag, valid_a, va ? 1 : 0);
        chk("os_count_a", tag, int'(count_a), va ? n - LAT_A : 0);
        chk("os_valid_b", tag, valid_b, vb ? 1 : 0);
        chk("os_count_b", tag, int'(count_b), vb ? n - LAT_B : 0);
    endtask

    // One-shot pass with en held high; optional stray start (mode=1) pulse.
    task automatic run_oneshot(input int restart_at);
        start = 1'b1; mode = 1'b0; en = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        check_pass(0, 1'b0, 0);
        for (int j = 1; j <= MAX + LAT_B + 1; j++) begin
            start = (j == restart_at);
            mode  = (j == restart_at);
            tick();
            check_pass(j, (j == MAX + LAT_B), j);
        end
        start = 1'b0; mode = 1'b0;
    endtask

    initial begin
        int n;

        rst = 1'b1; en = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;

        //              st mo ab en  cnt bsy fst lst va ca vb dn
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // Short directed vectors: start, en stall, ignored start, abort
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start; mode = tbl[i].mode; abort = tbl[i].abort; en = tbl[i].en;
            tick();
            chk("tbl_count",   i, int'(count),   tbl[i].e_count);
            chk("tbl_busy",    i, busy,          tbl[i].e_busy);
            chk("tbl_first",   i, first,         tbl[i].e_first);
            chk("tbl_last",    i, last,          tbl[i].e_last);
            chk("tbl_valid_a", i, valid_a,       tbl[i].e_vld_a);
            chk("tbl_count_a", i, int'(count_a), tbl[i].e_cnt_a);
            chk("tbl_valid_b", i, valid_b,       tbl[i].e_vld_b);
            chk("tbl_done",    i, done,          tbl[i].e_done);
        end
        start = 1'b0; mode = 1'b0; abort = 1'b0; en = 1'b1;

        // Full one-shot pass, en constantly high
        run_oneshot(0);
`ifdef SCHED_PASS_CNT_EN
        chk("os_pass_cnt", 0, int'(pass_cnt), 1);
`endif

        // One-shot with en toggling every cycle
        start = 1'b1; mode = 1'b0; en = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        check_pass(0, 1'b0, 0);
        for (int c = 1; c < 2000; c++) begin
            en = (c % 2 == 1);
            tick();
            if (en) n++;
            check_pass(n, en && (n == MAX + LAT_B), c);
            if (n == MAX + LAT_B + 1) break;
        end
        chk("toggle_reach", 0, n, MAX + LAT_B + 1);
        en = 1'b1;

        // One-shot with a free-run start request mid-pass: must be ignored
        run_oneshot(51);

        // Free-run for three passes
        start = 1'b1; mode = 1'b1; en = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        chk("fr_count0", 0, int'(count), 0);
        chk("fr_first0", 0, first, 1);
        for (int j = 1; j <= 3 * MAX; j++) begin
            tick();
            chk("fr_count",   j, int'(count), j % MAX);
            chk("fr_first",   j, first, (j % MAX == 0) ? 1 : 0);
            chk("fr_last",    j, last, (j % MAX == MAX - 1) ? 1 : 0);
            chk("fr_busy",    j, busy, 1);
            chk("fr_done",    j, done, 0);
            chk("fr_valid_b", j, valid_b, (j >= LAT_B) ? 1 : 0);
            chk("fr_count_b", j, int'(count_b), (j >= LAT_B) ? (j - LAT_B) % MAX : 0);
        end
`ifdef SCHED_PASS_CNT_EN
        chk("fr_pass_cnt", 0, int'(pass_cnt), 3);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("fr_abort");
`ifdef SCHED_PASS_CNT_EN
        chk("abort_keeps_pass_cnt", 0, int'(pass_cnt), 3);
`endif

        // Abort together with start at count=100
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 100; j++) tick();
        chk("ab_count100", 0, int'(count), 100);
        abort = 1'b1; start = 1'b1; mode = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; mode = 1'b0;
        chk_idle("ab_next");
        tick();
        chk_idle("ab_after");

        // Asynchronous reset between edges mid-pass
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 50; j++) tick();
        chk("rst_pre_count", 0, int'(count), 50);
        chk("rst_pre_count_a", 0, int'(count_a), 47);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("rst_async");
`ifdef SCHED_PASS_CNT_EN
        chk("rst_pass_cnt", 0, int'(pass_cnt), 0);
`endif
        tick();
        rst = 1'b0;
        run_oneshot(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
